// File: rtl/mc_mem_responder.sv
// Unified word memory responder for the multicycle MIPS core: fixed-latency
// read/write with a one-cycle ready pulse. Optional MEM_ALIGN_CHECK_EN flags misaligned accesses.
module mc_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int         AW        = $clog2(DEPTH);
    localparam bit         DIRECT    = (LATENCY == 1);
    localparam logic [3:0] WAIT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          cap_we;
    logic          cap_mis;
    logic [AW-1:0] cap_idx;
    logic [31:0]   cap_wd;
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] req_idx;
    logic          req_mis;
    logic          commit;
    logic          c_we;
    logic          c_mis;
    logic [AW-1:0] c_idx;
    logic [31:0]   c_wd;
    logic          unused_addr;

    assign req_idx     = addr[AW+1:2];
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign req_mis = (addr[1:0] != 2'b00);
`else
    assign req_mis = 1'b0;
`endif

    // With LATENCY = 1 the commit uses the live request, otherwise the captured one.
    always_comb begin
        commit = 1'b0;
        c_we   = cap_we;
        c_idx  = cap_idx;
        c_wd   = cap_wd;
        c_mis  = cap_mis;
        if (DIRECT && state == IDLE && req) begin
            commit = 1'b1;
            c_we   = we;
            c_idx  = req_idx;
            c_wd   = wd;
            c_mis  = req_mis;
        end else if (state == WAIT && cnt == 4'd0) begin
            commit = 1'b1;
        end
    end

    // Reset on the commit edge blocks the write; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && commit && c_we && !c_mis) begin
            mem[c_idx] <= c_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            rd      <= 32'h0;
            cap_we  <= 1'b0;
            cap_mis <= 1'b0;
            cap_idx <= '0;
            cap_wd  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_we  <= we;
                        cap_idx <= req_idx;
                        cap_wd  <= wd;
                        cap_mis <= req_mis;
                        busy    <= 1'b1;
                        if (DIRECT) begin
                            state <= RESP;
                        end else begin
                            cnt   <= WAIT_INIT;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            ready <= commit;
            err   <= commit & c_mis;
            if (commit && !c_we && !c_mis) begin
                rd <= mem[c_idx];
            end
        end
    end
endmodule
